// File: rtl/hamming_encode_tx_if.sv
// Nibble handshake and serial-line bundle for hamming_encode_tx.
// err_pos only exists when HAMMING_ERR_INJECT_EN is defined.
interface hamming_encode_tx_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx_bit;
    logic       tx_busy;
    logic       frame_done;
`ifdef HAMMING_ERR_INJECT_EN
    logic [2:0] err_pos;

    modport master (output in_data, in_valid, err_pos,
                    input  in_ready, tx_bit, tx_busy, frame_done);
    modport slave  (input  in_data, in_valid, err_pos,
                    output in_ready, tx_bit, tx_busy, frame_done);
`else
    modport master (output in_data, in_valid,
                    input  in_ready, tx_bit, tx_busy, frame_done);
    modport slave  (input  in_data, in_valid,
                    output in_ready, tx_bit, tx_busy, frame_done);
`endif
endinterface

// File: rtl/hamming_encode_tx.sv
// Hamming(7,4) transmit framer: header 110, codeword c6..c0, then GAP idle zeros.
// Optional HAMMING_ERR_INJECT_EN flips codeword bit err_pos-1 after encoding.
module hamming_encode_tx #(
    parameter int unsigned GAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    hamming_encode_tx_if.slave bus
);
    localparam logic [2:0] HDR      = 3'b110;
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    // State names the bit launched at the next edge, so the FSM is back in
    // IDLE while the last gap bit is still on the line.
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_GAP} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [6:0] cw, cw_nx;
    logic       bit_q, busy_q, done_q;
    logic       bit_nx, busy_nx, done_nx;
    logic       accept;
    logic [6:0] enc;
    logic [6:0] err_mask;

    assign bus.in_ready   = (state == S_IDLE) & ~rst;
    assign bus.tx_bit     = bit_q;
    assign bus.tx_busy    = busy_q;
    assign bus.frame_done = done_q;
    assign accept         = bus.in_valid & bus.in_ready;

    assign enc = {bus.in_data,
                  bus.in_data[3] ^ bus.in_data[2] ^ bus.in_data[1],
                  bus.in_data[3] ^ bus.in_data[2] ^ bus.in_data[0],
                  bus.in_data[3] ^ bus.in_data[1] ^ bus.in_data[0]};

`ifdef HAMMING_ERR_INJECT_EN
    always_comb begin
        err_mask = '0;
        for (int k = 0; k < 7; k++)
            err_mask[k] = (bus.err_pos == 3'(k + 1));
    end
`else
    assign err_mask = '0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cw_nx    = cw;
        bit_nx   = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cw_nx    = enc ^ err_mask;
                    bit_nx   = HDR[2];
                    busy_nx  = 1'b1;
                    state_nx = S_HDR;
                    cnt_nx   = 4'd1;
                end
            end
            S_HDR: begin
                bit_nx  = (cnt == 4'd1) ? HDR[1] : HDR[0];
                busy_nx = 1'b1;
                if (cnt == 4'd2) begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            S_DATA: begin
                bit_nx  = cw[3'd6 - cnt[2:0]];
                busy_nx = 1'b1;
                if (cnt == 4'd6) begin
                    state_nx = S_GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            S_GAP: begin
                busy_nx = 1'b1;
                if (cnt == GAP_LAST) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cw     <= '0;
            bit_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            cw     <= cw_nx;
            bit_q  <= bit_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end
endmodule
